// File: rtl/trap_filter_mc_if.sv
// Stream handshake bundle (tdata/tvalid/tready) used for both the ADC sample
// input and the filtered output of trap_filter_mc.
interface trap_filter_mc_if #(
    parameter int WIDTH = 16
) ();
    logic signed [WIDTH-1:0] tdata;
    logic                    tvalid;
    logic                    tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/trap_filter_mc.sv
// Trapezoidal (Jordanov-Knoll) pulse shaper with runtime K/L/M reconfiguration,
// zero-primed ring-buffer delay lines, sample-advanced pipeline and saturating output.
module trap_filter_mc #(
    parameter int DATA_WIDTH = 16,
    parameter int MAX_DELAY  = 4096,
    parameter int M_WIDTH    = 24,
    parameter int M_FRAC     = 8,
    parameter int ACC_WIDTH  = 48,
    parameter int OUT_WIDTH  = 32,
    parameter int OUT_SHIFT  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    trap_filter_mc_if.slave             s_axis,
    trap_filter_mc_if.master            m_axis,
    input  logic [$clog2(MAX_DELAY):0]  cfg_k,
    input  logic [$clog2(MAX_DELAY):0]  cfg_l,
    input  logic signed [M_WIDTH-1:0]   cfg_m,
    input  logic                        cfg_load,
    output logic                        cfg_err,
    output logic                        sat_flag
);
    localparam int AW = $clog2(MAX_DELAY);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH    = CW'(MAX_DELAY);
    localparam logic [AW-1:0] LAST_PTR = AW'(MAX_DELAY - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    localparam logic signed [ACC_WIDTH-1:0] OUT_MAX =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] OUT_MIN =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    // Read address dly entries behind the write pointer; dly == MAX_DELAY lands on
    // the slot about to be overwritten, which still holds the oldest sample.
    function automatic logic [AW-1:0] ring_rd(input logic [AW-1:0] wp, input logic [CW-1:0] dly);
        logic [CW:0] t;
        t = {2'b00, wp} + {1'b0, DEPTH} - {1'b0, dly};
        if (t >= {1'b0, DEPTH}) begin
            t = t - {1'b0, DEPTH};
        end
        return t[AW-1:0];
    endfunction

    function automatic logic [AW-1:0] ring_next(input logic [AW-1:0] wp);
        return (wp == LAST_PTR) ? '0 : wp + 1'b1;
    endfunction

    logic [1:0]                   state;
    logic [CW-1:0]                k_q, l_q;
    logic signed [M_WIDTH-1:0]    m_q;
    logic [AW-1:0]                wp_k, wp_l;
    logic [CW-1:0]                fill_k, fill_l;
    logic signed [DATA_WIDTH-1:0] mem_k [MAX_DELAY];
    logic signed [ACC_WIDTH-1:0]  mem_l [MAX_DELAY];
    logic [4:0]                   vld;
    logic signed [ACC_WIDTH-1:0]  kd_r, d_r, p_r, prod_r, r_r, s_r;
    logic signed [OUT_WIDTH-1:0]  out_r;
    logic                         tvalid_r;

    logic                         advance, enter_check, cfg_ok;
    logic signed [DATA_WIDTH-1:0] xk;
    logic signed [ACC_WIDTH-1:0]  x_ext, xk_ext, kd_dly, m_ext, s_shift;
    logic signed [OUT_WIDTH-1:0]  out_next;
    logic                         clamp;

    assign s_axis.tready = (state == ST_RUN);
    assign m_axis.tdata  = out_r;
    assign m_axis.tvalid = tvalid_r;

    // A sample arriving together with cfg_load is dropped by the re-prime.
    assign advance     = s_axis.tvalid && (state == ST_RUN) && !cfg_load;
    assign enter_check = cfg_load && (state != ST_CHECK);
    assign cfg_ok      = (k_q != '0) && (k_q <= l_q) && (l_q <= DEPTH);

    always_comb begin
        xk       = (fill_k >= k_q) ? mem_k[ring_rd(wp_k, k_q)] : '0;
        kd_dly   = (fill_l >= l_q) ? mem_l[ring_rd(wp_l, l_q)] : '0;
        x_ext    = {{(ACC_WIDTH-DATA_WIDTH){s_axis.tdata[DATA_WIDTH-1]}}, s_axis.tdata};
        xk_ext   = {{(ACC_WIDTH-DATA_WIDTH){xk[DATA_WIDTH-1]}}, xk};
        m_ext    = {{(ACC_WIDTH-M_WIDTH){m_q[M_WIDTH-1]}}, m_q};
        s_shift  = s_r >>> OUT_SHIFT;
        clamp    = 1'b0;
        out_next = s_shift[OUT_WIDTH-1:0];
        if (s_shift > OUT_MAX) begin
            out_next = {1'b0, {(OUT_WIDTH-1){1'b1}}};
            clamp    = 1'b1;
        end else if (s_shift < OUT_MIN) begin
            out_next = {1'b1, {(OUT_WIDTH-1){1'b0}}};
            clamp    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && advance) begin
            mem_k[wp_k] <= s_axis.tdata;
            if (vld[0]) begin
                mem_l[wp_l] <= kd_r;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            k_q      <= '0;
            l_q      <= '0;
            m_q      <= '0;
            wp_k     <= '0;
            wp_l     <= '0;
            fill_k   <= '0;
            fill_l   <= '0;
            vld      <= '0;
            kd_r     <= '0;
            d_r      <= '0;
            p_r      <= '0;
            prod_r   <= '0;
            r_r      <= '0;
            s_r      <= '0;
            out_r    <= '0;
            tvalid_r <= 1'b0;
            cfg_err  <= 1'b0;
            sat_flag <= 1'b0;
        end else begin
            tvalid_r <= 1'b0;

            case (state)
                ST_IDLE:  if (cfg_load) state <= ST_CHECK;
                ST_CHECK: begin
                    state   <= cfg_ok ? ST_RUN : ST_IDLE;
                    cfg_err <= !cfg_ok;
                end
                ST_RUN:   if (cfg_load) state <= ST_CHECK;
                default:  state <= ST_IDLE;
            endcase

            if (enter_check) begin
                k_q      <= cfg_k;
                l_q      <= cfg_l;
                m_q      <= cfg_m;
                wp_k     <= '0;
                wp_l     <= '0;
                fill_k   <= '0;
                fill_l   <= '0;
                vld      <= '0;
                p_r      <= '0;
                s_r      <= '0;
                sat_flag <= 1'b0;
            end else if (advance) begin
                // Every stage moves one step per accepted sample; gaps freeze everything.
                vld    <= {vld[3:0], 1'b1};
                wp_k   <= ring_next(wp_k);
                fill_k <= (fill_k == DEPTH) ? fill_k : fill_k + 1'b1;
                kd_r   <= x_ext - xk_ext;
                if (vld[0]) begin
                    wp_l   <= ring_next(wp_l);
                    fill_l <= (fill_l == DEPTH) ? fill_l : fill_l + 1'b1;
                    d_r    <= kd_r - kd_dly;
                end
                if (vld[1]) begin
                    p_r    <= p_r + d_r;
                    prod_r <= d_r * m_ext;
                end
                if (vld[2]) begin
                    r_r <= p_r + (prod_r >>> M_FRAC);
                end
                if (vld[3]) begin
                    s_r <= s_r + r_r;
                end
                if (vld[4]) begin
                    out_r    <= out_next;
                    tvalid_r <= 1'b1;
                    if (clamp) begin
                        sat_flag <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_trap_filter_mc.sv
// Scoreboard bench for trap_filter_mc: directed pulses push hand-computed outputs,
// an independent monitor pops and compares whenever m_axis_tvalid is seen.
module tb_trap_filter_mc;
    localparam int DW = 16;
    localparam int MD = 16;
    localparam int MW = 24;
    localparam int MF = 8;
    localparam int AW = 48;
    localparam int OW = 16;
    localparam int OS = 0;
    localparam int CW = $clog2(MD) + 1;

    logic clk = 1'b0;
    logic rst;
    logic [CW-1:0] cfg_k, cfg_l;
    logic signed [MW-1:0] cfg_m;
    logic cfg_load;
    logic cfg_err, sat_flag;

    always #5 clk = ~clk;

    trap_filter_mc_if #(.WIDTH(DW)) s_if ();
    trap_filter_mc_if #(.WIDTH(OW)) m_if ();
    assign m_if.tready = 1'b1;

    trap_filter_mc #(
        .DATA_WIDTH(DW), .MAX_DELAY(MD), .M_WIDTH(MW), .M_FRAC(MF),
        .ACC_WIDTH(AW), .OUT_WIDTH(OW), .OUT_SHIFT(OS)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axis(s_if), .m_axis(m_if),
        .cfg_k(cfg_k), .cfg_l(cfg_l), .cfg_m(cfg_m),
        .cfg_load(cfg_load), .cfg_err(cfg_err), .sat_flag(sat_flag)
    );

    int n_compared   = 0;
    int n_mismatched = 0;
    int exp_q[$];
    int cyc          = 0;
    int out_count    = 0;
    int accepted     = 0;
    int imp_cyc      = 0;
    bit lat_arm      = 1'b0;

    int t1_exp[7] = '{100, 200, 200, 200, 100, 0, 0};
    int t2_exp[8] = '{200, 300, 200, 200, 0, -100, 0, 0};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic signed [63:0] actual,
                               input logic signed [63:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Monitor: every presented output is matched against the oldest expectation.
    always @(negedge clk) begin : monitor
        int e;
        if (cyc > 0 && m_if.tvalid === 1'b1) begin
            out_count++;
            if (lat_arm) begin
                lat_arm = 1'b0;
                checkOutput("latency", cyc - imp_cyc, 6);
            end
            if (exp_q.size() == 0) begin
                n_compared++;
                n_mismatched++;
                $display("[TB] FAIL unexpected_tvalid: got tvalid=1 data=%0d, expected no output",
                         m_if.tdata);
            end else begin
                e = exp_q.pop_front();
                checkOutput("tdata", m_if.tdata, e);
            end
        end
    end

    task automatic applyStimulus(input int data, input bit valid);
        @(negedge clk);
        s_if.tdata  = DW'(data);
        s_if.tvalid = valid;
        if (valid && s_if.tready) accepted++;
    endtask

    task automatic loadConfig(input int k, input int l, input int m, input bit expect_err);
        @(negedge clk);
        s_if.tvalid = 1'b0;
        cfg_k       = CW'(k);
        cfg_l       = CW'(l);
        cfg_m       = MW'(m);
        cfg_load    = 1'b1;
        @(negedge clk);
        cfg_load = 1'b0;
        @(negedge clk);
        checkOutput("cfg_err", cfg_err, expect_err);
        checkOutput("tready_after_cfg", s_if.tready, !expect_err);
    endtask

    task automatic feedPulse(input int amp, input int n, input int gap,
                             input bit constant, input bit arm);
        for (int i = 0; i < n; i++) begin
            if (i > 0) repeat (gap) applyStimulus(0, 1'b0);
            applyStimulus((i == 0 || constant) ? amp : 0, 1'b1);
            if (i == 0 && arm) begin
                imp_cyc = cyc;
                lat_arm = 1'b1;
            end
        end
        applyStimulus(0, 1'b0);
    endtask

    task automatic drainCheck(input string name);
        repeat (3) @(negedge clk);
        #1;
        checkOutput(name, exp_q.size(), 0);
    endtask

    initial begin : watchdog
        #200000;
        n_mismatched++;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin : main
        int out0, acc0;
        rst         = 1'b1;
        cfg_k       = '0;
        cfg_l       = '0;
        cfg_m       = '0;
        cfg_load    = 1'b0;
        s_if.tdata  = '0;
        s_if.tvalid = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_tready", s_if.tready, 0);
        checkOutput("reset_tvalid", m_if.tvalid, 0);
        checkOutput("reset_tdata", m_if.tdata, 0);
        checkOutput("reset_cfg_err", cfg_err, 0);
        checkOutput("reset_sat_flag", sat_flag, 0);
        rst = 1'b0;

        $display("[TB] impulse K=2 L=4 M=0");
        loadConfig(2, 4, 0, 1'b0);
        foreach (t1_exp[i]) exp_q.push_back(t1_exp[i]);
        feedPulse(100, 12, 0, 1'b0, 1'b1);
        drainCheck("m0_drain");

        $display("[TB] impulse K=2 L=4 M=1.0");
        loadConfig(2, 4, 1 << MF, 1'b0);
        foreach (t2_exp[i]) exp_q.push_back(t2_exp[i]);
        feedPulse(100, 13, 0, 1'b0, 1'b0);
        drainCheck("m1_drain");
        checkOutput("sat_flag_quiet", sat_flag, 0);

        $display("[TB] impulse with tvalid every third cycle");
        loadConfig(2, 4, 0, 1'b0);
        out0 = out_count;
        acc0 = accepted;
        foreach (t1_exp[i]) exp_q.push_back(t1_exp[i]);
        feedPulse(100, 12, 2, 1'b0, 1'b0);
        drainCheck("gap_drain");
        checkOutput("gap_accepted", accepted - acc0, 12);
        // Five samples remain in flight behind the last accepted one.
        checkOutput("gap_tvalid_count", out_count - out0, 7);

        $display("[TB] invalid then boundary configuration");
        loadConfig(5, 3, 0, 1'b1);
        loadConfig(1, MD, 0, 1'b0);
        for (int i = 0; i < MD; i++) exp_q.push_back(100);
        exp_q.push_back(0);
        exp_q.push_back(0);
        feedPulse(100, MD + 7, 0, 1'b0, 1'b0);
        drainCheck("kmax_drain");

        $display("[TB] saturation with constant full-scale input");
        loadConfig(2, 4, 0, 1'b0);
        for (int i = 0; i < 6; i++) exp_q.push_back(32767);
        feedPulse(32767, 11, 0, 1'b1, 1'b0);
        drainCheck("sat_drain");
        checkOutput("sat_flag_set", sat_flag, 1);
        loadConfig(2, 4, 0, 1'b0);
        checkOutput("sat_flag_cleared", sat_flag, 0);

        $display("[TB] reset mid-pulse");
        exp_q.push_back(100);
        exp_q.push_back(200);
        exp_q.push_back(200);
        feedPulse(100, 8, 0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        checkOutput("pre_rst_queue", exp_q.size(), 0);
        checkOutput("pre_rst_tdata", m_if.tdata, 200);
        rst         = 1'b1;
        s_if.tdata  = DW'(50);
        s_if.tvalid = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("post_rst_tvalid", m_if.tvalid, 0);
        end
        checkOutput("post_rst_tdata", m_if.tdata, 0);
        checkOutput("post_rst_tready", s_if.tready, 0);
        checkOutput("post_rst_sat_flag", sat_flag, 0);
        checkOutput("post_rst_cfg_err", cfg_err, 0);
        s_if.tvalid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
